// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word memory between the
// instruction-fetch port and the data port of the core. Accesses are
// serialised; each request is issued exactly once and acked one cycle later.
// Out-of-range addresses are never sent to the memory and raise a sticky err.
module mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              err
);

    // State records which port was issued in the previous cycle; its ack is due now.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t state_reg;
    logic   oor_reg;        // the access being acked was out of range
    logic   err_reg;

    logic   issue_i;
    logic   issue_d;
    logic   i_oor;
    logic   d_oor;
    logic   issue_oor;

    // Byte-lane bits of the addresses are deliberately ignored (word memory).
    logic   unused_lane_bits;
    assign unused_lane_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign i_oor = |i_addr[31:ADDR_W+2];
    assign d_oor = |d_addr[31:ADDR_W+2];

    // Grant decision: D wins from IDLE; while one port is being acked only the
    // other port may be issued, so a still-high req is never issued twice.
    always_comb begin
        issue_i = 1'b0;
        issue_d = 1'b0;
        case (state_reg)
            IDLE: begin
                if (d_req) begin
                    issue_d = 1'b1;
                end else if (i_req) begin
                    issue_i = 1'b1;
                end
            end
            BUSY_D:  issue_i = i_req;
            BUSY_I:  issue_d = d_req;
            default: ;
        endcase
    end

    assign issue_oor = issue_d ? d_oor : (issue_i ? i_oor : 1'b0);

    // Memory strobe is suppressed for out-of-range issues and while in reset.
    assign mem_en    = rst & (issue_d | issue_i) & ~issue_oor;
    assign mem_we    = mem_en & issue_d & d_we;
    assign mem_addr  = issue_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
    assign mem_wdata = d_wdata;

    // FSM: track the issued port, whether that access was out of range, and sticky err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            oor_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if (issue_d) begin
                state_reg <= BUSY_D;
            end else if (issue_i) begin
                state_reg <= BUSY_I;
            end else begin
                state_reg <= IDLE;
            end
            oor_reg <= issue_oor;
            if (issue_oor) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign i_ack   = (state_reg == BUSY_I);
    assign d_ack   = (state_reg == BUSY_D);
    assign i_rdata = (i_ack && !oor_reg) ? mem_rdata : 32'd0;
    assign d_rdata = (d_ack && !oor_reg) ? mem_rdata : 32'd0;
    assign err     = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural synchronous memory, scoreboard queues
// of expected read data per port, and one task per scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_req = 1'b0;
    logic [31:0]       i_addr = '0;
    logic              i_ack;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [31:0]       d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        chk;
        logic [31:0] val;
    } exp_t;

    exp_t i_q[$];
    exp_t d_q[$];

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory model: preloaded while in reset, synchronous read/write afterwards.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (!rst) begin
            for (int a = 0; a < (1 << ADDR_W); a++) begin
                mem[a] <= 32'hA500_0000 | a;
            end
            mem[1]    <= 32'd7;
            mem[2]    <= 32'hDEAD_BEEF;
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    function automatic exp_t mk(input logic chk, input logic [31:0] val);
        exp_t e;
        e.chk = chk;
        e.val = val;
        return e;
    endfunction

    // Scoreboard: every ack pops one expectation; rdata must be 0 without an ack.
    always @(negedge clk) begin
        exp_t e;
        if (d_ack) begin
            if (d_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d_unexpected_ack t=%0t d_rdata=%h expected no ack", $time, d_rdata);
            end else begin
                e = d_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (d_rdata !== e.val) begin
                        failures++;
                        $display("FAIL d_rdata t=%0t got=%h expected=%h", $time, d_rdata, e.val);
                    end
                end
                $display("d ack t=%0t d_rdata=%h", $time, d_rdata);
            end
        end else begin
            checks++;
            if (d_rdata !== 32'd0) begin
                failures++;
                $display("FAIL d_rdata_idle t=%0t got=%h expected=00000000", $time, d_rdata);
            end
        end
        if (i_ack) begin
            if (i_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL i_unexpected_ack t=%0t i_rdata=%h expected no ack", $time, i_rdata);
            end else begin
                e = i_q.pop_front();
                if (e.chk) begin
                    checks++;
                    if (i_rdata !== e.val) begin
                        failures++;
                        $display("FAIL i_rdata t=%0t got=%h expected=%h", $time, i_rdata, e.val);
                    end
                end
                $display("i ack t=%0t i_rdata=%h", $time, i_rdata);
            end
        end else begin
            checks++;
            if (i_rdata !== 32'd0) begin
                failures++;
                $display("FAIL i_rdata_idle t=%0t got=%h expected=00000000", $time, i_rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({i_ack, d_ack, err, mem_en, mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b expected=00000", {i_ack, d_ack, err, mem_en, mem_we});
        end
        step();
        d_req  = 1'b1;
        d_addr = 32'h4;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_en_gated got=%b expected=0", mem_en);
        end
        step();
        d_req = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        checks++;
        if ({i_ack, d_ack, mem_en} !== 3'b0) begin
            failures++;
            $display("FAIL reset_release got=%b expected=000", {i_ack, d_ack, mem_en});
        end
    endtask

    task automatic test_fetch();
        step();
        i_req  = 1'b1;
        i_addr = 32'h8;
        i_q.push_back(mk(1'b1, 32'hDEAD_BEEF));
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'd2) begin
            failures++;
            $display("FAIL fetch_issue en_we=%b addr=%0d expected en_we=10 addr=2", {mem_en, mem_we}, mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (i_ack !== 1'b1 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack i_ack=%b mem_en=%b expected i_ack=1 mem_en=0", i_ack, mem_en);
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_ack, mem_en} !== 2'b00) begin
            failures++;
            $display("FAIL fetch_idle i_ack=%b mem_en=%b expected 0 0", i_ack, mem_en);
        end
    endtask

    task automatic test_write_read();
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h10;
        d_wdata = 32'h1234_5678;
        d_q.push_back(mk(1'b0, 32'd0));
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 10'd4 || mem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL write_issue en_we=%b addr=%0d wdata=%h expected 11 4 12345678", {mem_en, mem_we}, mem_addr, mem_wdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (d_ack !== 1'b1) begin
            failures++;
            $display("FAIL write_ack d_ack=%b expected=1", d_ack);
        end
        step();
        d_req  = 1'b0;
        d_we   = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h10;
        i_q.push_back(mk(1'b1, 32'h1234_5678));
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 10'd4) begin
            failures++;
            $display("FAIL readback_issue en_we=%b addr=%0d expected 10 4", {mem_en, mem_we}, mem_addr);
        end
        step();
        @(negedge clk);
        step();
        i_req = 1'b0;
    endtask

    task automatic test_priority();
        step();
        i_req  = 1'b1;
        i_addr = 32'h20;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h4;
        d_q.push_back(mk(1'b1, 32'd7));
        i_q.push_back(mk(1'b1, 32'hA500_0008));
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 10'd1) begin
            failures++;
            $display("FAIL prio_first en=%b addr=%0d expected en=1 addr=1 (D first)", mem_en, mem_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if ({d_ack, i_ack, mem_en} !== 3'b101 || mem_addr !== 10'd8) begin
            failures++;
            $display("FAIL prio_second d_ack,i_ack,en=%b addr=%0d expected 101 addr=8", {d_ack, i_ack, mem_en}, mem_addr);
        end
        step();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_ack, i_ack, mem_en} !== 3'b010) begin
            failures++;
            $display("FAIL prio_third d_ack,i_ack,en=%b expected 010", {d_ack, i_ack, mem_en});
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_ack, i_ack, mem_en} !== 3'b000) begin
            failures++;
            $display("FAIL prio_idle d_ack,i_ack,en=%b expected 000", {d_ack, i_ack, mem_en});
        end
    endtask

    task automatic test_back_to_back();
        int dk = 0;
        int ik = 0;
        int d_acks = 0;
        int i_acks = 0;
        logic d_seen;
        logic i_seen;
        logic [ADDR_W-1:0] exp_addr;
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'd16 << 2;
        i_req  = 1'b1;
        i_addr = 32'd32 << 2;
        d_q.push_back(mk(1'b1, 32'hA500_0010));
        i_q.push_back(mk(1'b1, 32'hA500_0020));
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            d_seen = d_ack;
            i_seen = i_ack;
            if (d_seen) d_acks++;
            if (i_seen) i_acks++;
            checks++;
            if (c < 8) begin
                exp_addr = (c % 2 == 0) ? ADDR_W'(16 + dk) : ADDR_W'(32 + ik);
                if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
                    failures++;
                    $display("FAIL b2b_grant c=%0d en=%b addr=%0d expected en=1 addr=%0d", c, mem_en, mem_addr, exp_addr);
                end
            end else if (mem_en !== 1'b0) begin
                failures++;
                $display("FAIL b2b_tail en=%b expected=0", mem_en);
            end
            step();
            if (d_seen) begin
                if (dk < 3) begin
                    dk++;
                    d_addr = 32'(16 + dk) << 2;
                    d_q.push_back(mk(1'b1, 32'hA500_0000 | 32'(16 + dk)));
                end else begin
                    d_req = 1'b0;
                end
            end
            if (i_seen) begin
                if (ik < 3) begin
                    ik++;
                    i_addr = 32'(32 + ik) << 2;
                    i_q.push_back(mk(1'b1, 32'hA500_0000 | 32'(32 + ik)));
                end else begin
                    i_req = 1'b0;
                end
            end
        end
        checks++;
        if (d_acks != 4 || i_acks != 4) begin
            failures++;
            $display("FAIL b2b_ack_count d=%0d i=%0d expected 4 4", d_acks, i_acks);
        end
    endtask

    task automatic test_range();
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h1000;
        d_q.push_back(mk(1'b1, 32'd0));
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL range_issue en=%b err=%b expected 0 0", mem_en, err);
        end
        step();
        @(negedge clk);
        checks++;
        if (d_ack !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL range_ack d_ack=%b err=%b expected 1 1", d_ack, err);
        end
        // Out-of-range write whose low bits alias word 4: must be dropped.
        step();
        d_we    = 1'b1;
        d_addr  = 32'h1000_0010;
        d_wdata = 32'h0000_0BAD;
        d_q.push_back(mk(1'b0, 32'd0));
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin
            failures++;
            $display("FAIL range_write_issue en_we=%b expected 00", {mem_en, mem_we});
        end
        step();
        @(negedge clk);
        step();
        d_req  = 1'b0;
        d_we   = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h10;
        i_q.push_back(mk(1'b1, 32'h1234_5678));
        @(negedge clk);
        step();
        @(negedge clk);
        // Highest in-range word.
        step();
        i_addr = 32'hFFC;
        i_q.push_back(mk(1'b1, 32'hA500_03FF));
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 10'd1023) begin
            failures++;
            $display("FAIL range_top_issue en=%b addr=%0d expected 1 1023", mem_en, mem_addr);
        end
        step();
        @(negedge clk);
        step();
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL range_err_sticky err=%b expected=1", err);
        end
    endtask

    task automatic test_async_reset();
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h8;
        @(negedge clk);
        step();
        #1;
        checks++;
        if (d_ack !== 1'b1) begin
            failures++;
            $display("FAIL areset_busy d_ack=%b expected=1", d_ack);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({d_ack, mem_en, err} !== 3'b000) begin
            failures++;
            $display("FAIL areset_drop d_ack,en,err=%b expected 000", {d_ack, mem_en, err});
        end
        step();
        d_req = 1'b0;
        rst   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({d_ack, i_ack, mem_en} !== 3'b000) begin
                failures++;
                $display("FAIL areset_stale c=%0d d_ack,i_ack,en=%b expected 000", c, {d_ack, i_ack, mem_en});
            end
        end
    endtask

    task automatic test_drain();
        checks++;
        if (i_q.size() != 0 || d_q.size() != 0) begin
            failures++;
            $display("FAIL missing_acks pending_i=%0d pending_d=%0d expected 0 0", i_q.size(), d_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_priority();
        test_back_to_back();
        test_range();
        test_drain();
        test_async_reset();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port synchronous word memory between the Beta core's instruction-fetch port and its data port.
- Both ports use a req/ack handshake. The arbiter serialises their accesses, guarantees each request is issued exactly once, and flags out-of-range addresses.
- Sits between core and the memory; replaces separate i_mem/d_mem in the SoC top.

Parameters:
- ADDR_W, 10, word-address width of the memory (memory depth 2^ADDR_W words).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request; held with i_addr stable until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle
- i_rdata  out  32  fetched word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle for reads
- d_rdata  out  32  load data
- mem_en  out  1  memory access strobe, sampled on clk rise
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid one cycle after mem_en (synchronous read)
- err  out  1  sticky out-of-range flag

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE immediately.
  - Outputs go to 0 immediately: i_ack, d_ack, err, mem_en, mem_we.
  - i_rdata and d_rdata read 0.
  - Any in-flight access is dropped; no ack is produced for it after reset releases.
- States: IDLE, BUSY_I, BUSY_D. A state register records which port was issued in the previous cycle.
- Issue cycle (combinational outputs):
  - mem_en=1.
  - mem_addr = addr[ADDR_W+1:2].
  - mem_we = d_we for D, 0 for I.
  - mem_wdata = d_wdata.
  - addr[1:0] are ignored.
- Range rule: an address is out of range when addr[31:ADDR_W+2] != 0. The arbiter then:
  - holds mem_en=0 in the issue cycle;
  - still moves to BUSY_x and acks next cycle;
  - returns rdata = 0;
  - discards the write;
  - sets err=1 at that edge. err stays 1 until reset.
- IDLE:
  - d_req → issue D, go to BUSY_D.
  - Else i_req → issue I, go to BUSY_I.
  - Else stay IDLE.
  - Both pending → D wins (data access belongs to the older instruction).
- BUSY_D:
  - d_ack=1; d_rdata = mem_rdata (or 0 if out of range). Writes also get d_ack.
  - D is not re-issued this cycle (d_req is still high).
  - If i_req → issue I, go to BUSY_I; else go to IDLE.
- BUSY_I: mirror of BUSY_D.
  - i_ack=1, i_rdata = mem_rdata.
  - If d_req → issue D, go to BUSY_D; else go to IDLE.
- Latency: ack arrives exactly one cycle after issue. Each port sustains at most one access every 2 cycles. With both ports saturated, the memory is busy every cycle, strictly alternating D,I,D,I.
- rdata outputs are 0 whenever the corresponding ack is 0.
- Requester must drop req in the cycle after its ack, or present a new request then. The arbiter treats req high in the cycle after ack as a new request.
- A req raised or dropped while that port is not yet granted has no side effects.
- No internal buffering: at most one outstanding access.

Test Plan:
- mem[2]=0xDEADBEEF; i_req, i_addr=0x8 from IDLE → cycle0 mem_en=1, mem_we=0, mem_addr=2; cycle1 i_ack=1, i_rdata=0xDEADBEEF; cycle2 IDLE, mem_en=0.
- d_req, d_we=1, d_addr=0x10, d_wdata=0x12345678 → mem_we=1, mem_addr=4; d_ack next cycle. Then i_req i_addr=0x10 → i_rdata=0x12345678.
- i_req and d_req (read 0x4, mem[1]=7) raised together in IDLE → D issued first. Next cycle: d_ack with d_rdata=7 and I issued. Cycle after: i_ack. Exactly one ack per port, no duplicate mem_en.
- Both requesters hold req continuously (new request each cycle after ack) for 8 cycles → mem_en=1 every cycle, grants D,I,D,I,…; 4 acks each.
- ADDR_W=10, d read d_addr=0x1000 → mem_en=0; d_ack next cycle with d_rdata=0; err=1 and stays 1 through later valid accesses until rst=0.
- Assert rst=0 mid-cycle while in BUSY_D → d_ack and mem_en drop to 0 immediately. After release with no req, the block stays IDLE and no stale ack is produced.
